icb_sram_slv: RTL and testbench
===============================

// Module: icb_sram_slv
// PURPOSE
//  ICB responder (slave) fronting one on-chip word SRAM bank (SRAM1/SRAM2 feature-map store).
//  Serves the conv accelerator's ICB master: word reads of input data, full/masked word writes of results.
//  Accepts one cmd per cycle; returns one rsp per cmd, in order, through a RSP_DEPTH-entry response FIFO.
//  Decodes its address window and answers out-of-window commands with rsp_err instead of an access.
// PARAMETERS
//  BASE_ADDR  32'h2000_0000  window base; cmd_addr[31:AW] must equal BASE_ADDR[31:AW]
//  AW         16             word-index width; word index = cmd_addr[AW-1:0] (1 address step = 1 word)
//  DEPTH      50776          implemented words (0xC658); index >= DEPTH is out of window
//  RSP_DEPTH  2              response FIFO entries (>=1)
// PORTS
//  clk            in   1   clock
//  rst_n          in   1   asynchronous, active-low reset
//  icb_cmd_valid  in   1   command valid
//  icb_cmd_ready  out  1   command accept
//  icb_cmd_addr   in   32  command address (word-indexed, see AW)
//  icb_cmd_read   in   1   1 = read, 0 = write
//  icb_cmd_wdata  in   32  write data
//  icb_cmd_wmask  in   4   byte enables, bit i -> wdata[8i+7:8i]
//  icb_rsp_valid  out  1   response valid (FIFO non-empty)
//  icb_rsp_ready  in   1   response accept
//  icb_rsp_rdata  out  32  read data (0 for writes and errors)
//  icb_rsp_err    out  1   1 = cmd was out of window
//  err_cnt        out  8   count of err responses pushed, saturates at 8'hFF
// BEHAVIOUR
//  Reset values: icb_rsp_valid=0, icb_rsp_rdata=0, icb_rsp_err=0, err_cnt=0, FIFO empty -> icb_cmd_ready=1.
//  SRAM array not reset; contents survive reset. Reset mid-burst drops all queued rsps, no partial writes.
//  cmd handshake = icb_cmd_valid & icb_cmd_ready; icb_cmd_ready = (fifo_count < RSP_DEPTH), registered-state only,
//   no combinational path from icb_rsp_ready or icb_cmd_valid.
//  On cmd handshake at edge N (single edge does everything):
//   - in-window write: SRAM bytes with wmask=1 updated; FIFO push {rdata=0, err=0}
//   - in-window read : SRAM word read (sees all writes from edges < N); FIFO push {rdata=word, err=0}
//   - out-of-window  : no SRAM access; FIFO push {rdata=0, err=1}; err_cnt += 1 unless 8'hFF
//  Latency: rsp visible at icb_rsp_valid in the cycle after edge N when FIFO was empty (1 cycle).
//  rsp handshake = icb_rsp_valid & icb_rsp_ready pops head; outputs always show head entry.
//  Push and pop at the same edge: count unchanged; with RSP_DEPTH=2 and rsp_ready=1 -> 1 cmd/cycle sustained.
//  Full (count==RSP_DEPTH): cmd_ready=0 even if a pop occurs that edge; ready rises the next cycle.
//  Empty: rsp_valid=0; rdata/err hold last popped values (not required to be 0).
//  Pointers wrap modulo RSP_DEPTH; count width clog2(RSP_DEPTH+1).
//  Commands complete strictly in order; rsp_valid held with stable data until popped.
//  wmask=4'b0000 write: no byte changes, normal err=0 response.
// TESTING
//  1 write addr 0x2000_0005 wdata 0xDEAD_BEEF mask 4'hF, then read 0x2000_0005 -> rsp rdata 0xDEAD_BEEF, err 0, 1-cycle latency
//  2 write 0x1122_3344 mask F, then 0xAABB_CCDD mask 4'b0101 same addr, read -> 0x11BB_33DD
//  3 rsp_ready=1, 100 back-to-back reads 0x2000_0000..0x2000_0063 -> cmd_ready stays 1, 100 in-order rsps
//  4 rsp_ready=0, issue 3 reads -> 2 accepted, cmd_ready=0; raise rsp_ready -> 3rd accepted the cycle after first pop
//  5 read 0x3000_0000 and 0x2000_C658 -> two rsps err=1 rdata=0, err_cnt=2, SRAM unchanged
//  6 assert rst_n=0 with 2 rsps queued -> rsp_valid=0 immediately, cmd_ready=1 after release, prior SRAM data intact

Source files
------------

// File: rtl/icb_sram_slv.sv
// rtl/icb_sram_slv.sv - ICB responder for one on-chip word SRAM bank with in-order response FIFO
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   icb_cmd_valid/ready             command handshake (ready depends on registered FIFO state only)
//   icb_cmd_addr/read/wdata/wmask   command payload; addr is word-indexed, wmask bit i -> byte i
//   icb_rsp_valid/ready             response handshake (valid = FIFO non-empty)
//   icb_rsp_rdata/err               head response; err = command fell outside the window
//   err_cnt                         saturating count of error responses pushed
module icb_sram_slv #(
    parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
    parameter int          AW        = 16,
    parameter int          DEPTH     = 50776,
    parameter int          RSP_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        icb_cmd_valid,
    output logic        icb_cmd_ready,
    input  logic [31:0] icb_cmd_addr,
    input  logic        icb_cmd_read,
    input  logic [31:0] icb_cmd_wdata,
    input  logic [3:0]  icb_cmd_wmask,
    output logic        icb_rsp_valid,
    input  logic        icb_rsp_ready,
    output logic [31:0] icb_rsp_rdata,
    output logic        icb_rsp_err,
    output logic [7:0]  err_cnt
);

    localparam int             PW       = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int             CW       = $clog2(RSP_DEPTH + 1);
    localparam logic [PW-1:0]  PTR_LAST = PW'(RSP_DEPTH - 1);
    localparam logic [CW-1:0]  CNT_FULL = CW'(RSP_DEPTH);
    localparam logic [AW:0]    DEPTH_W  = (AW + 1)'(DEPTH);

    logic [31:0]          mem [DEPTH];

    logic [31:0]          fifo_rdata [RSP_DEPTH];
    logic [RSP_DEPTH-1:0] fifo_err;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        count;
    logic [CW-1:0]        count_nxt;
    logic [31:0]          last_rdata;
    logic                 last_err;

    logic [AW-1:0]        cmd_idx;
    logic                 in_window;
    logic                 cmd_fire;
    logic                 rsp_fire;
    logic                 mem_wr;
    logic [31:0]          push_rdata;
    logic                 push_err;

    assign cmd_idx   = icb_cmd_addr[AW-1:0];
    assign in_window = (icb_cmd_addr[31:AW] == BASE_ADDR[31:AW]) && ({1'b0, cmd_idx} < DEPTH_W);

    assign icb_cmd_ready = (count < CNT_FULL);
    assign icb_rsp_valid = (count != '0);
    assign cmd_fire      = icb_cmd_valid & icb_cmd_ready;
    assign rsp_fire      = icb_rsp_valid & icb_rsp_ready;

    // Gated by rst_n so a command presented while reset is asserted cannot touch the array.
    assign mem_wr = rst_n & cmd_fire & in_window & ~icb_cmd_read;

    // Read returns the array value before this edge's update; a read and a write never share an edge.
    always_comb begin
        push_rdata = 32'h0;
        push_err   = 1'b0;
        if (!in_window) begin
            push_err = 1'b1;
        end else if (icb_cmd_read) begin
            push_rdata = mem[cmd_idx];
        end
    end

    // Array is deliberately not reset so feature maps survive a controller reset.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (icb_cmd_wmask[i]) begin
                    mem[cmd_idx][8*i +: 8] <= icb_cmd_wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        count_nxt = count;
        if (cmd_fire && !rsp_fire) begin
            count_nxt = count + CW'(1);
        end else if (!cmd_fire && rsp_fire) begin
            count_nxt = count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            fifo_err   <= '0;
            last_rdata <= 32'h0;
            last_err   <= 1'b0;
            err_cnt    <= 8'h00;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                fifo_rdata[i] <= 32'h0;
            end
        end else begin
            count <= count_nxt;
            if (cmd_fire) begin
                fifo_rdata[wr_ptr] <= push_rdata;
                fifo_err[wr_ptr]   <= push_err;
                wr_ptr             <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
                if (push_err && err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'h01;
                end
            end
            if (rsp_fire) begin
                last_rdata <= fifo_rdata[rd_ptr];
                last_err   <= fifo_err[rd_ptr];
                rd_ptr     <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
            end
        end
    end

    // When empty the outputs keep showing the most recently popped response rather than a stale slot.
    assign icb_rsp_rdata = (count == '0) ? last_rdata : fifo_rdata[rd_ptr];
    assign icb_rsp_err   = (count == '0) ? last_err   : fifo_err[rd_ptr];

endmodule

// File: tb/tb_icb_sram_slv.sv
// tb/tb_icb_sram_slv.sv - self-checking bench for icb_sram_slv
module tb_icb_sram_slv;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        icb_cmd_valid;
    logic        icb_cmd_ready;
    logic [31:0] icb_cmd_addr;
    logic        icb_cmd_read;
    logic [31:0] icb_cmd_wdata;
    logic [3:0]  icb_cmd_wmask;
    logic        icb_rsp_valid;
    logic        icb_rsp_ready;
    logic [31:0] icb_rsp_rdata;
    logic        icb_rsp_err;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    icb_sram_slv dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .icb_cmd_valid (icb_cmd_valid),
        .icb_cmd_ready (icb_cmd_ready),
        .icb_cmd_addr  (icb_cmd_addr),
        .icb_cmd_read  (icb_cmd_read),
        .icb_cmd_wdata (icb_cmd_wdata),
        .icb_cmd_wmask (icb_cmd_wmask),
        .icb_rsp_valid (icb_rsp_valid),
        .icb_rsp_ready (icb_rsp_ready),
        .icb_rsp_rdata (icb_rsp_rdata),
        .icb_rsp_err   (icb_rsp_err),
        .err_cnt       (err_cnt)
    );

    int          tests = 0;
    int          fails = 0;
    logic [31:0] model_mem [int];
    logic [31:0] exp_rdata_q [$];
    logic        exp_err_q [$];
    int          exp_errcnt = 0;
    logic [31:0] last_rdata;
    logic        last_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit in_win(input logic [31:0] a);
        return (a[31:16] == 16'h2000) && (a[15:0] < 16'hC658);
    endfunction

    // One clock: checks registered outputs mid-cycle, then applies the edge's effects to the model.
    task automatic cycle(output bit fired);
        logic [31:0] old, nw;
        @(negedge clk);
        chk("rsp_valid", {31'b0, icb_rsp_valid}, {31'b0, exp_rdata_q.size() > 0});
        chk("cmd_ready", {31'b0, icb_cmd_ready}, {31'b0, exp_rdata_q.size() < 2});
        chk("err_cnt", {24'b0, err_cnt}, exp_errcnt);
        if (icb_rsp_valid && exp_rdata_q.size() > 0) begin
            chk("rsp_rdata", icb_rsp_rdata, exp_rdata_q[0]);
            chk("rsp_err", {31'b0, icb_rsp_err}, {31'b0, exp_err_q[0]});
            if (icb_rsp_ready) begin
                last_rdata = icb_rsp_rdata;
                last_err   = icb_rsp_err;
                void'(exp_rdata_q.pop_front());
                void'(exp_err_q.pop_front());
            end
        end
        fired = icb_cmd_valid && icb_cmd_ready;
        if (fired) begin
            if (!in_win(icb_cmd_addr)) begin
                exp_rdata_q.push_back(32'h0);
                exp_err_q.push_back(1'b1);
                if (exp_errcnt < 255) exp_errcnt++;
            end else if (icb_cmd_read) begin
                exp_rdata_q.push_back(model_mem[int'(icb_cmd_addr[15:0])]);
                exp_err_q.push_back(1'b0);
            end else begin
                old = model_mem.exists(int'(icb_cmd_addr[15:0])) ? model_mem[int'(icb_cmd_addr[15:0])] : 32'h0;
                for (int i = 0; i < 4; i++) begin
                    nw[8*i +: 8] = icb_cmd_wmask[i] ? icb_cmd_wdata[8*i +: 8] : old[8*i +: 8];
                end
                model_mem[int'(icb_cmd_addr[15:0])] = nw;
                exp_rdata_q.push_back(32'h0);
                exp_err_q.push_back(1'b0);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input bit rd, input logic [31:0] wd,
                         input logic [3:0] m, output int waited);
        bit f;
        icb_cmd_valid = 1'b1;
        icb_cmd_addr  = a;
        icb_cmd_read  = rd;
        icb_cmd_wdata = wd;
        icb_cmd_wmask = m;
        f      = 1'b0;
        waited = 0;
        while (!f && waited < 50) begin
            if (waited >= 3) icb_rsp_ready = 1'b1;
            cycle(f);
            waited++;
        end
        chk("cmd_accepted", {31'b0, f}, 32'h1);
        icb_cmd_valid = 1'b0;
    endtask

    task automatic drain();
        bit f;
        int n;
        icb_cmd_valid = 1'b0;
        icb_rsp_ready = 1'b1;
        n = 0;
        while (exp_rdata_q.size() > 0 && n < 20) begin
            cycle(f);
            n++;
        end
        chk("drained", exp_rdata_q.size(), 0);
    endtask

    initial begin
        int w, total;
        bit f;
        logic [31:0] a;
        rst_n         = 1'b0;
        icb_cmd_valid = 1'b0;
        icb_cmd_addr  = 32'h0;
        icb_cmd_read  = 1'b0;
        icb_cmd_wdata = 32'h0;
        icb_cmd_wmask = 4'h0;
        icb_rsp_ready = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_rsp_valid", {31'b0, icb_rsp_valid}, 32'h0);
        chk("rst_rsp_rdata", icb_rsp_rdata, 32'h0);
        chk("rst_rsp_err", {31'b0, icb_rsp_err}, 32'h0);
        chk("rst_err_cnt", {24'b0, err_cnt}, 32'h0);
        chk("rst_cmd_ready", {31'b0, icb_cmd_ready}, 32'h1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // prefill the words used below
        icb_rsp_ready = 1'b1;
        for (int i = 0; i < 100; i++) issue(32'h2000_0000 + i, 1'b0, $urandom, 4'hF, w);
        for (int i = 16'hC650; i < 16'hC658; i++) issue(32'h2000_0000 + i, 1'b0, $urandom, 4'hF, w);
        drain();

        // 1: full write then read, 1-cycle latency
        issue(32'h2000_0005, 1'b0, 32'hDEAD_BEEF, 4'hF, w);
        issue(32'h2000_0005, 1'b1, 32'h0, 4'h0, w);
        drain();
        chk("t1_rdata", last_rdata, 32'hDEAD_BEEF);

        // 2: masked write merge, then zero-mask write changes nothing
        issue(32'h2000_0010, 1'b0, 32'h1122_3344, 4'hF, w);
        issue(32'h2000_0010, 1'b0, 32'hAABB_CCDD, 4'b0101, w);
        issue(32'h2000_0010, 1'b0, 32'hFFFF_FFFF, 4'b0000, w);
        issue(32'h2000_0010, 1'b1, 32'h0, 4'h0, w);
        drain();
        chk("t2_rdata", last_rdata, 32'h11BB_33DD);

        // 3: 100 back-to-back reads with no stall
        total = 0;
        for (int i = 0; i < 100; i++) begin
            issue(32'h2000_0000 + i, 1'b1, 32'h0, 4'h0, w);
            total += w;
        end
        drain();
        chk("t3_cycles", total, 100);

        // 4: backpressure, full FIFO stalls the third read until one cycle after the first pop
        icb_rsp_ready = 1'b0;
        issue(32'h2000_0001, 1'b1, 32'h0, 4'h0, w);
        issue(32'h2000_0002, 1'b1, 32'h0, 4'h0, w);
        icb_cmd_valid = 1'b1;
        icb_cmd_addr  = 32'h2000_0003;
        icb_cmd_read  = 1'b1;
        for (int i = 0; i < 3; i++) cycle(f);
        icb_rsp_ready = 1'b1;
        w = 0;
        f = 1'b0;
        while (!f && w < 10) begin
            cycle(f);
            w++;
        end
        chk("t4_wait", w, 2);
        drain();

        // 5: out-of-window reads, then the array is untouched
        issue(32'h3000_0000, 1'b1, 32'h0, 4'h0, w);
        issue(32'h2000_C658, 1'b1, 32'h0, 4'h0, w);
        drain();
        @(negedge clk);
        chk("t5_err_cnt", {24'b0, err_cnt}, 32'h2);
        chk("t5_last_err", {31'b0, last_err}, 32'h1);
        chk("t5_last_rdata", last_rdata, 32'h0);
        @(posedge clk);
        #1;
        issue(32'h2000_0005, 1'b1, 32'h0, 4'h0, w);
        issue(32'h2000_C657, 1'b1, 32'h0, 4'h0, w);
        drain();

        // randomized mix against the model
        for (int k = 0; k < 300; k++) begin
            icb_rsp_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) begin
                a = ($urandom_range(0, 1) == 0) ? {16'h3000, 16'($urandom)}
                                                : {16'h2000, 16'hC658 + 16'($urandom_range(0, 16'h39A7))};
            end else begin
                a = 32'h2000_0000 + $urandom_range(0, 99);
            end
            issue(a, 1'($urandom), $urandom, 4'($urandom), w);
            if ($urandom_range(0, 4) == 0) cycle(f);
        end
        drain();

        // err_cnt saturation
        for (int k = 0; k < 260; k++) issue(32'hF000_0000 + k, 1'b1, 32'h0, 4'h0, w);
        drain();
        @(negedge clk);
        chk("sat_err_cnt", {24'b0, err_cnt}, 32'hFF);
        @(posedge clk);
        #1;

        // 6: reset with two responses queued
        icb_rsp_ready = 1'b0;
        issue(32'h2000_0007, 1'b0, 32'hCAFE_F00D, 4'hF, w);
        issue(32'h2000_0005, 1'b1, 32'h0, 4'h0, w);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rsp_valid", {31'b0, icb_rsp_valid}, 32'h0);
        chk("t6_err_cnt", {24'b0, err_cnt}, 32'h0);
        exp_rdata_q.delete();
        exp_err_q.delete();
        exp_errcnt = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t6_cmd_ready", {31'b0, icb_cmd_ready}, 32'h1);
        @(posedge clk);
        #1;
        icb_rsp_ready = 1'b1;
        issue(32'h2000_0007, 1'b1, 32'h0, 4'h0, w);
        drain();
        chk("t6_rdata7", last_rdata, 32'hCAFE_F00D);
        issue(32'h2000_0005, 1'b1, 32'h0, 4'h0, w);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
